uart_rx_ctrl: RTL and testbench

- Receive-side controller between the UART byte receiver and its consumer.
- Buffers received bytes in a FIFO and drives RTS flow control with hysteresis.
- Detects line-idle gaps to mark burst boundaries and flags overruns.
- Consumer side uses a valid/ready stream.

---
 rtl/uart_rx_ctrl_if.sv | 22 ++
 rtl/uart_rx_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side byte stream of the UART receive controller.
// Head byte plus burst-last flag, valid/ready handshake.
interface uart_rx_ctrl_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, RTS hysteresis,
// idle-gap burst marking and sticky overrun flag.
module uart_rx_ctrl #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int HIGH_MARK = 12,
  parameter int LOW_MARK  = 4,
  parameter int IDLE_CLK  = 1740
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rts,
  output logic          burst_end,
  output logic          overrun,
  input  logic          overrun_clr,
  output logic [AW:0]   fill,
  uart_rx_ctrl_if.master cons
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HI   = (AW+1)'(HIGH_MARK);
  localparam logic [AW:0] LO   = (AW+1)'(LOW_MARK);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [15:0] TMO  = 16'(IDLE_CLK - 1);

  typedef enum logic {RUN, HOLD} state_t;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] last_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic [15:0]   idle_cnt;
  logic          armed;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  logic          fire;
  logic          mark;
  logic [8:0]    head;
  state_t        state;

  assign full     = (cnt == FULL);
  assign pop      = (cnt != '0) && cons.out_ready;
  assign push     = rx_valid && (!full || pop);
  assign drop     = rx_valid && full && !pop;
  assign cnt_nxt  = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign last_ptr = wr_ptr - AW'(1);

  // A reload on rx_valid always beats the timeout.
  assign fire = armed && !rx_valid && (idle_cnt == TMO);
  // Newest entry still buffered and not leaving this cycle.
  assign mark = fire && (cnt != '0) && !(pop && cnt == ONE);

  assign head           = mem[rd_ptr];
  assign cons.out_valid = (cnt != '0);
  assign cons.out_data  = cons.out_valid ? head[7:0] : 8'h00;
  assign cons.out_last  = cons.out_valid ? head[8] : 1'b0;
  assign fill           = cnt;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {1'b0, rx_data};
    if (mark)
      mem[last_ptr][8] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      idle_cnt  <= '0;
      burst_end <= 1'b0;
    end else begin
      burst_end <= 1'b0;
      if (rx_valid) begin
        armed    <= 1'b1;
        idle_cnt <= '0;
      end else if (fire) begin
        armed     <= 1'b0;
        burst_end <= 1'b1;
      end else if (armed) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rts   <= 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (cnt_nxt >= HI) begin
            state <= HOLD;
            rts   <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_nxt <= LO) begin
            state <= RUN;
            rts   <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          rts   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed steps plus random traffic
// compared every cycle with a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HIGH  = 12;
  localparam int LOW   = 4;
  localparam int IDLE  = 1740;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rts;
  logic        burst_end;
  logic        overrun;
  logic        overrun_clr;
  logic [AW:0] fill;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .HIGH_MARK(HIGH),
    .LOW_MARK(LOW), .IDLE_CLK(IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rts(rts), .burst_end(burst_end),
    .overrun(overrun), .overrun_clr(overrun_clr),
    .fill(fill), .cons(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int be_seen = 0;

  // Reference model
  logic [8:0] q[$];
  bit m_ovr;
  bit m_rts;
  bit m_armed;
  int m_last_rx;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 0;
    m_rts = 1;
    m_armed = 0;
    m_last_rx = 0;
  endtask

  task automatic check_all(input string tag);
    logic [8:0] h;
    h = (q.size() != 0) ? q[0] : 9'h000;
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, ".data"}, 32'(bus.out_data), 32'(h[7:0]));
    chk({tag, ".last"}, 32'(bus.out_last), 32'(h[8]));
    chk({tag, ".fill"}, 32'(fill), 32'(q.size()));
    chk({tag, ".rts"}, 32'(rts), 32'(m_rts));
    chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic tick(input string tag);
    bit pop, push, drop, full, be;
    pop  = (q.size() != 0) && bus.out_ready;
    full = (q.size() == DEPTH);
    push = rx_valid && (!full || pop);
    drop = rx_valid && full && !pop;
    @(posedge clk);
    #1;
    cyc++;
    if (pop) void'(q.pop_front());
    if (push) q.push_back({1'b0, rx_data});
    if (drop) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    be = 0;
    if (rx_valid) begin
      m_armed = 1;
      m_last_rx = cyc;
    end else if (m_armed && (cyc - m_last_rx) == IDLE) begin
      be = 1;
      m_armed = 0;
      if (q.size() != 0) q[q.size()-1][8] = 1'b1;
    end
    if (m_rts && q.size() >= HIGH) m_rts = 0;
    else if (!m_rts && q.size() <= LOW) m_rts = 1;
    if (burst_end) be_seen++;
    chk({tag, ".be"}, 32'(burst_end), 32'(be));
    check_all(tag);
  endtask

  task automatic push_byte(input logic [7:0] d, input string tag);
    rx_valid = 1'b1;
    rx_data  = d;
    tick(tag);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int be0;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    overrun_clr = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.data", 32'(bus.out_data), 32'd0);
    chk("rst.last", 32'(bus.out_last), 32'd0);
    chk("rst.rts", 32'(rts), 32'd1);
    chk("rst.be", 32'(burst_end), 32'd0);
    chk("rst.ovr", 32'(overrun), 32'd0);
    chk("rst.fill", 32'(fill), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single byte, latency 1
    bus.out_ready = 1'b1;
    push_byte(8'h5A, "t1");
    chk("t1.v", 32'(bus.out_valid), 32'd1);
    chk("t1.d", 32'(bus.out_data), 32'h5A);
    tick("t1p");
    chk("t1.f0", 32'(fill), 32'd0);
    idle(IDLE + 20, "t1i");

    // Idle burst marking
    bus.out_ready = 1'b0;
    be0 = be_seen;
    push_byte(8'h11, "t2");
    idle(869, "t2i");
    push_byte(8'h22, "t2");
    idle(869, "t2i");
    push_byte(8'h33, "t2");
    idle(IDLE, "t2w");
    chk("t2.be_count", 32'(be_seen - be0), 32'd1);
    bus.out_ready = 1'b1;
    chk("t2.last0", 32'(bus.out_last), 32'd0);
    tick("t2p");
    chk("t2.last1", 32'(bus.out_last), 32'd0);
    tick("t2p");
    chk("t2.d2", 32'(bus.out_data), 32'h33);
    chk("t2.last2", 32'(bus.out_last), 32'd1);
    tick("t2p");

    // RTS hysteresis
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_byte(8'(8'h40 + i), "t3");
    chk("t3.fill12", 32'(fill), 32'd12);
    chk("t3.rts0", 32'(rts), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'b1;
      tick("t3p");
      bus.out_ready = 1'b0;
      if (i == 6) chk("t3.rts_at5", 32'(rts), 32'd0);
    end
    chk("t3.rts_at4", 32'(rts), 32'd1);
    bus.out_ready = 1'b1;
    idle(4, "t3d");

    // Overrun
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(8'hA0 + i), "t4");
    push_byte(8'hEE, "t4x");
    chk("t4.ovr", 32'(overrun), 32'd1);
    chk("t4.fill", 32'(fill), 32'd16);
    bus.out_ready = 1'b1;
    chk("t4.head", 32'(bus.out_data), 32'hA0);
    idle(16, "t4p");
    overrun_clr = 1'b1;
    tick("t4c");
    overrun_clr = 1'b0;
    chk("t4.clr", 32'(overrun), 32'd0);

    // Full with simultaneous push and pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(8'hC0 + i), "t5");
    bus.out_ready = 1'b1;
    push_byte(8'h77, "t5x");
    chk("t5.ovr", 32'(overrun), 32'd0);
    chk("t5.fill", 32'(fill), 32'd16);
    idle(15, "t5p");
    chk("t5.tail", 32'(bus.out_data), 32'h77);
    idle(2, "t5p");

    // Wrap with continuous pop, then async reset at fill 5
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_byte(8'(8'h10 + 3 * i), "t6");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h90 + i), "t6");
    chk("t6.fill5", 32'(fill), 32'd5);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6.rst_fill", 32'(fill), 32'd0);
    chk("t6.rst_rts", 32'(rts), 32'd1);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    be0 = be_seen;
    idle(IDLE + 40, "t6r");
    chk("t6.no_be", 32'(be_seen - be0), 32'd0);

    // Random traffic
    for (int i = 0; i < 8000; i++) begin
      if ((i % 2000) >= 1900) begin
        rx_valid = 1'b0;
        bus.out_ready = 1'b0;
        if ((i % 2000) == 1900) idle(IDLE + 5, "rnd_gap");
      end else begin
        rx_valid = ($urandom_range(0, 2) == 0);
        rx_data = 8'($urandom);
        if ((i / 500) % 2 == 0)
          bus.out_ready = ($urandom_range(0, 3) != 0);
        else
          bus.out_ready = ($urandom_range(0, 5) == 0);
      end
      overrun_clr = ($urandom_range(0, 40) == 0);
      tick("rnd");
    end
    rx_valid = 1'b0;
    overrun_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
